// File: rtl/test_dout_pkg.sv
// Shared types and pattern constants for the test data generator.
// Pure declarations; no timing behaviour or backpressure of its own.
package test_dout_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Galois feedback masks, applied after the right shift when the dropped bit is 1
  function automatic logic [31:0] lfsr_taps(input int dwidth);
    case (dwidth)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

  // The reserved encoding behaves as increment
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_LFSR;
      2'd2:    return MODE_WALK;
      default: return MODE_INC;
    endcase
  endfunction

endpackage

// File: rtl/test_dout_pattern.sv
// Pattern value and successor for the currently selected channel.
// Latency: purely combinational. Backpressure: none, the caller decides when to commit.
module test_dout_pattern
  import test_dout_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int BURST_LEN = 8,
  parameter int CW        = 2
) (
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] seed,
  input  logic [CW-1:0]     ch,
  input  logic              first,
  input  logic [DWIDTH-1:0] state,
  output logic [DWIDTH-1:0] cur,
  output logic [DWIDTH-1:0] nxt
);

  localparam logic [DWIDTH-1:0] TAPS = DWIDTH'(lfsr_taps(DWIDTH));
  localparam logic [DWIDTH-1:0] ONE  = DWIDTH'(1);
  localparam logic [DWIDTH-1:0] BL   = DWIDTH'(BURST_LEN);

  logic [DWIDTH-1:0] ch_ext;
  logic [DWIDTH-1:0] init_val;

  assign ch_ext = DWIDTH'(ch);

  always_comb begin
    init_val = seed + ch_ext * BL;
    case (mode)
      MODE_LFSR: begin
        init_val = seed ^ ch_ext;
        // an all-zero LFSR would lock up
        if (init_val == '0) init_val = ONE;
      end
      MODE_WALK: init_val = ONE << (int'(ch) % DWIDTH);
      default:   init_val = seed + ch_ext * BL;
    endcase
  end

  // A channel's register is only meaningful once it has sent its first beat
  assign cur = first ? init_val : state;

  always_comb begin
    nxt = cur + ONE;
    case (mode)
      MODE_LFSR: nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
      MODE_WALK: nxt = {cur[DWIDTH-2:0], cur[DWIDTH-1]};
      default:   nxt = cur + ONE;
    endcase
  end

endmodule

// File: rtl/test_dout_gen.sv
// Multi-channel test pattern source, optional pause input via TEST_DOUT_GEN_PAUSE_EN.
// Latency: first beat valid the cycle after start; one beat per cycle while ready.
// Backpressure: valid/ready, presented beat held stable until accepted.
module test_dout_gen
  import test_dout_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int CH_NUM    = 4,
  parameter int BURST_LEN = 8,
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int RW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] seed,
`ifdef TEST_DOUT_GEN_PAUSE_EN
  input  logic              pause,
`endif
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DWIDTH-1:0] dout_data,
  output logic [CW-1:0]     dout_ch,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic              vld_q;
  logic [CW-1:0]     ch_idx;
  logic [RW-1:0]     round;
  logic [1:0]        mode_q;
  logic [DWIDTH-1:0] seed_q;
  logic [DWIDTH-1:0] ch_state [CH_NUM];
  logic [DWIDTH-1:0] sel_state;
  logic [DWIDTH-1:0] pat_cur, pat_nxt;
  logic              hs, is_last, pause_w;

`ifdef TEST_DOUT_GEN_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign hs      = vld_q && dout_ready;
  assign is_last = (ch_idx == CW'(CH_NUM - 1)) && (round == RW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hs && is_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_state = '0;
    for (int c = 0; c < CH_NUM; c++)
      if (ch_idx == CW'(c)) sel_state = ch_state[c];
  end

  test_dout_pattern #(
    .DWIDTH    (DWIDTH),
    .BURST_LEN (BURST_LEN),
    .CW        (CW)
  ) u_pattern (
    .mode  (mode_q),
    .seed  (seed_q),
    .ch    (ch_idx),
    .first (round == '0),
    .state (sel_state),
    .cur   (pat_cur),
    .nxt   (pat_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ch_idx <= '0;
      round  <= '0;
      mode_q <= MODE_INC;
      seed_q <= '0;
      for (int c = 0; c < CH_NUM; c++) ch_state[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vld_q  <= !pause_w;
            ch_idx <= '0;
            round  <= '0;
            mode_q <= decode_mode(mode);
            seed_q <= seed;
          end
        end
        RUN: begin
          if (hs) begin
            for (int c = 0; c < CH_NUM; c++)
              if (ch_idx == CW'(c)) ch_state[c] <= pat_nxt;
            if (is_last) begin
              vld_q <= 1'b0;
            end else begin
              vld_q <= !pause_w;
              if (ch_idx == CW'(CH_NUM - 1)) begin
                ch_idx <= '0;
                round  <= round + RW'(1);
              end else begin
                ch_idx <= ch_idx + CW'(1);
              end
            end
          end else if (!vld_q) begin
            vld_q <= !pause_w;
          end
        end
        default: vld_q <= 1'b0;
      endcase
    end
  end

  assign dout_valid = vld_q;
  assign dout_data  = vld_q ? pat_cur : '0;
  assign dout_ch    = vld_q ? ch_idx : '0;
  assign dout_last  = vld_q && is_last;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_test_dout_gen.sv
// Bench for test_dout_gen: table of pattern runs checked beat-by-beat through a
// scoreboard queue, plus stall, abort, start-while-busy and pause sequences.
module tb_test_dout_gen;

  localparam int DW  = 16;
  localparam int CHN = 2;
  localparam int BL  = 3;
  localparam int NB  = CHN * BL;

  typedef struct packed {
    logic [1:0]           mode;
    logic [DW-1:0]        seed;
    logic [NB-1:0][DW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] seed = '0;
  logic          pause = 1'b0;
  logic          dout_ready = 1'b1;
  logic          dout_valid, dout_last, busy, done;
  logic [DW-1:0] dout_data;
  logic          dout_ch;

  vec_t          vecs [6];
  logic [17:0]   q [$];
  int            tests = 0, fails = 0;
  int            cyc = 0, hs_cnt = 0, done_cnt = 0, last_hs_cyc = -10, bubbles = 0;
  bit            rnd_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [18:0]   prev_out = '0;

  always #5 clk = ~clk;

  test_dout_gen #(.DWIDTH(DW), .CH_NUM(CHN), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
`ifdef TEST_DOUT_GEN_PAUSE_EN
    .pause      (pause),
`endif
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_ch    (dout_ch),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [DW-1:0] s,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                              input logic [DW-1:0] d4, input logic [DW-1:0] d5);
    vec_t v;
    v.mode = m; v.seed = s;
    v.exp[0] = d0; v.exp[1] = d1; v.exp[2] = d2;
    v.exp[3] = d3; v.exp[4] = d4; v.exp[5] = d5;
    return v;
  endfunction

  // Monitor: scoreboard pops on each handshake, stall hold, done placement
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {13'd0, dout_valid, dout_ch, dout_last, dout_data}, {13'd0, prev_out});
      if (busy && !dout_valid) bubbles++;
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        if (q.size() == 0) chk("unexpected_beat", {14'd0, dout_ch, dout_last, dout_data}, 32'hFFFF_FFFF);
        else begin
          chk("beat", {14'd0, dout_ch, dout_last, dout_data}, {14'd0, q.pop_front()});
          if (dout_last) last_hs_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_valid_low", {31'd0, dout_valid}, 32'd0);
        chk("done_timing", cyc, last_hs_cyc + 1);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_out   = {dout_valid, dout_ch, dout_last, dout_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      dout_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_vec(input int v);
    for (int i = 0; i < NB; i++)
      q.push_back({1'(i % CHN), (i == NB - 1), vecs[v].exp[i]});
  endtask

  task automatic run_vec(input int v, input bit rnd, input bit poke, input bit pz);
    int d0, left, exp_bub;
    bit poked, pzd;
    push_vec(v);
    hs_cnt = 0; bubbles = 0; d0 = done_cnt; left = 0; poked = 0; pzd = 0;
    @(posedge clk); #1;
    mode = vecs[v].mode; seed = vecs[v].seed; start = 1'b1; rnd_en = rnd;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'd2; seed = 16'hDEAD;
    @(negedge clk); #1;
    chk("start_latency", {31'd0, dout_valid}, 32'd1);
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (poke && !poked && hs_cnt >= 2) begin
        start = 1'b1; mode = 2'd1; seed = 16'h5555; poked = 1;
      end
      if (left > 0) begin
        left--;
        if (left == 0) pause = 1'b0;
      end else if (pz && !pzd && hs_cnt >= 2) begin
        pause = 1'b1; left = 5; pzd = 1;
      end
      @(negedge clk); #1;
    end
    rnd_en = 1'b0;
`ifdef TEST_DOUT_GEN_PAUSE_EN
    exp_bub = pz ? 5 : 0;
`else
    exp_bub = 0;
`endif
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", q.size(), 0);
    chk("beat_count", hs_cnt, NB);
    chk("bubbles", bubbles, exp_bub);
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    vecs[0] = mk(2'd0, 16'h0010, 16'h0010, 16'h0013, 16'h0011, 16'h0014, 16'h0012, 16'h0015);
    vecs[1] = mk(2'd0, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 16'h0003, 16'h0001, 16'h0004);
    vecs[2] = mk(2'd1, 16'h0000, 16'h0001, 16'h0001, 16'hB400, 16'hB400, 16'h5A00, 16'h5A00);
    vecs[3] = mk(2'd1, 16'h0003, 16'h0003, 16'h0002, 16'hB401, 16'h0001, 16'hEE00, 16'hB400);
    vecs[4] = mk(2'd2, 16'h1234, 16'h0001, 16'h0002, 16'h0002, 16'h0004, 16'h0004, 16'h0008);
    vecs[5] = mk(2'd3, 16'h0010, 16'h0010, 16'h0013, 16'h0011, 16'h0014, 16'h0012, 16'h0015);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {11'd0, dout_valid, dout_last, busy, done, dout_ch, dout_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(v, 1'b0, 1'b0, 1'b0);
    run_vec(0, 1'b1, 1'b0, 1'b0);
    run_vec(3, 1'b1, 1'b0, 1'b0);
    run_vec(0, 1'b0, 1'b1, 1'b0);
    run_vec(4, 1'b0, 1'b0, 1'b1);

    // Abort after the third transfer
    push_vec(0);
    hs_cnt = 0; d0 = done_cnt;
    @(posedge clk); #1;
    mode = vecs[0].mode; seed = vecs[0].seed; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached", hs_cnt, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_valid_low", {31'd0, dout_valid}, 32'd0);
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    q.delete();
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    run_vec(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_dout_gen.md
TEST_DOUT_GEN -- requirements
Module: test_dout_gen

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter CH_NUM, default 4, channel count; legal range 1..16.
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per channel per run; legal range 1..256.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, run request pulse.
REQ-007 SHALL have port mode, input, 2, pattern select: 0 increment, 1 LFSR, 2 walking-one, 3 reserved (treated as 0).
REQ-008 SHALL have port seed, input, DWIDTH, pattern seed.
REQ-009 SHALL have port dout_valid, output, 1, beat valid.
REQ-010 SHALL have port dout_ready, input, 1, sink ready.
REQ-011 SHALL have port dout_data, output, DWIDTH, beat data.
REQ-012 SHALL have port dout_ch, output, max(1,$clog2(CH_NUM)), channel of the current beat.
REQ-013 SHALL have port dout_last, output, 1, marks the final beat of a run.
REQ-014 SHALL have port busy, output, 1, high while in RUN.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at end of run.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on handshake of the last beat; DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL capture mode and seed in the start cycle; start in RUN or DONE SHALL be ignored.
REQ-018 SHALL assert dout_valid in the cycle after start is sampled (1-cycle latency).
REQ-019 SHALL count a transfer only in a cycle where dout_valid and dout_ready are both high.
REQ-020 SHALL hold dout_data, dout_ch, and dout_last stable while dout_valid is high and dout_ready is low.
REQ-021 SHALL support back-to-back transfers, one beat per cycle while dout_ready stays high.
REQ-022 SHALL interleave channels round-robin (0,1,..,CH_NUM-1,0,..) for a total of CH_NUM*BURST_LEN beats per run.
REQ-023 SHALL keep a per-channel state register; channel c initial state at start:
- increment: seed + c*BURST_LEN;
- LFSR: seed ^ c, forced to 1 if zero;
- walking-one: 1 << (c mod DWIDTH).
REQ-024 SHALL advance only the transferred channel's state:
- increment: +1 modulo 2^DWIDTH (wraps silently);
- LFSR: one Galois step using the package tap mask;
- walking-one: rotate left by 1.
REQ-025 SHALL assert dout_last only on beat CH_NUM*BURST_LEN-1 (channel CH_NUM-1, its final beat).
REQ-026 SHALL pulse done for exactly the DONE cycle, with dout_valid low in that cycle.
REQ-027 SHALL give priority to rst over start and handshake when they coincide.

Reset
REQ-028 SHALL, on rst high at a clock edge, set the state to IDLE and drive dout_valid, dout_last, busy, and done to 0, and dout_data and dout_ch to 0.
REQ-029 SHALL, on rst mid-run, abort the run, deassert dout_valid in the next cycle, and discard any partial progress.

Configuration
REQ-030 SHALL implement macro TEST_DOUT_GEN_PAUSE_EN, which when defined adds input port pause (1 bit).
REQ-031 SHALL, when pause is high, not raise dout_valid for a new beat, while a beat already presented stays valid until accepted.
REQ-032 SHALL, without TEST_DOUT_GEN_PAUSE_EN, have no pause port and never insert bubbles on its own.

Structure
REQ-033 SHALL place the following in package test_dout_pkg:
- mode enum (MODE_INC, MODE_LFSR, MODE_WALK);
- state enum (IDLE, RUN, DONE);
- function lfsr_taps(DWIDTH) returning Galois masks 8'hB8, 16'hB400, 32'h80200003.
REQ-034 SHALL place pattern init/advance in one sub-module, test_dout_pattern, instanced once, combinational next-state for the selected channel.

Verification
REQ-035 SHALL verify: CH_NUM=2, BURST_LEN=3, mode 0, seed 0x0010, ready=1 -> data 0x10,0x13,0x11,0x14,0x12,0x15; ch 0,1,0,1,0,1; last on 0x15; done one cycle later.
REQ-036 SHALL verify: mode 0, seed 0xFFFF, CH_NUM=1, BURST_LEN=3 -> 0xFFFF,0x0000,0x0001.
REQ-037 SHALL verify: dout_ready toggled pseudo-randomly -> no beat lost or duplicated, outputs stable during every stall, same sequence as REQ-035.
REQ-038 SHALL verify: mode 1, seed 0x0000, CH_NUM=1, DWIDTH=16 -> first beat 0x0001, second 0xB400.
REQ-039 SHALL verify: rst asserted after the 3rd transfer -> dout_valid 0 next cycle, no done pulse; a new start produces the full sequence from beat 0.
REQ-040 SHALL verify: start while busy -> ignored, run completes unchanged; with TEST_DOUT_GEN_PAUSE_EN, pause held 5 cycles between beats -> dout_valid low for those cycles, sequence unchanged.
